// File: rtl/brg_xcel_mem_pkg.sv
// Shared types and constants for the accelerator memory responder and its response pipe.
package brg_xcel_mem_pkg;

  // Response payload fields are sized for the widest supported configuration.
  // Narrower instances zero-extend into them.
  localparam int unsigned RESP_DATA_W = 64;
  localparam int unsigned RESP_OPQ_W  = 32;

  localparam logic TYPE_LOAD  = 1'b0;
  localparam logic TYPE_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                  val;
    logic [RESP_OPQ_W-1:0]  opq;
    logic [RESP_DATA_W-1:0] data;
  } resp_s;

endpackage

// File: rtl/brg_xcel_resp_pipe.sv
// Fixed-depth response shift register. Payload only advances with a valid entry,
// so the last stage holds its previous response while idle.
module brg_xcel_resp_pipe
  import brg_xcel_mem_pkg::*;
#(
  parameter int depth_p = 2
) (
  input  logic  clk_i,
  input  logic  reset_n_i,
  input  resp_s in_i,
  output resp_s out_o,
  output logic  any_valid_o
);

  resp_s src   [depth_p];
  resp_s stage_q [depth_p];

  genvar gi;
  generate
    for (gi = 0; gi < depth_p; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src[gi] = in_i;
      end else begin : g_tail
        assign src[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < depth_p; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth_p; i++) begin
        stage_q[i].val <= src[i].val;
        if (src[i].val) begin
          stage_q[i].opq  <= src[i].opq;
          stage_q[i].data <= src[i].data;
        end
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < depth_p; i++) begin
      any_valid_o = any_valid_o | stage_q[i].val;
    end
  end

  assign out_o = stage_q[depth_p-1];

endmodule

// File: rtl/brg_xcel_mem_responder.sv
// Scratchpad-backed responder for an accelerator master port: zero-fills on reset/clear,
// services byte-masked stores and fixed-latency loads that echo the load ID.
module brg_xcel_mem_responder
  import brg_xcel_mem_pkg::*;
#(
  parameter int unsigned             data_width_p    = 32,
  parameter int unsigned             addr_width_p    = 32,
  parameter int unsigned             load_id_width_p = 11,
  parameter int unsigned             els_p           = 1024,
  parameter int unsigned             latency_p       = 2,
  parameter logic [data_width_p-1:0] err_data_p      = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         master_val_i,
  input  logic                         master_type_i,
  input  logic [addr_width_p-1:0]      master_addr_i,
  input  logic [load_id_width_p-1:0]   master_opq_i,
  input  logic [data_width_p-1:0]      master_data_i,
  input  logic [(data_width_p>>3)-1:0] master_mask_i,
  output logic                         master_rdy_o,
  output logic [data_width_p-1:0]      master_ret_data_o,
  output logic [load_id_width_p-1:0]   master_ret_opq_o,
  output logic                         master_ret_val_o,
  input  logic                         clear_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned      IDX_W    = $clog2(els_p);
  localparam int unsigned      MASK_W   = data_width_p >> 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(els_p - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic                       meta_val_q, meta_oor_q, err_q;
  logic [load_id_width_p-1:0] meta_opq_q;
  logic [data_width_p-1:0]    rd_q;
  logic [data_width_p-1:0]    mem_q [els_p];

  logic                       accept, is_store, req_oor, pipe_busy, pipe_any_valid;
  logic                       init_we, ram_we, ram_re;
  logic [IDX_W-1:0]           req_idx, ram_idx;
  logic [MASK_W-1:0]          ram_be;
  logic [data_width_p-1:0]    ram_wdata;
  resp_s                      pipe_in, pipe_out;
  logic                       unused_bits;

  assign master_rdy_o = (state_q == ST_READY);
  assign busy_o       = ~master_rdy_o;
  assign err_o        = err_q;

  assign accept   = master_val_i & master_rdy_o;
  assign is_store = (master_type_i == TYPE_STORE);
  assign req_idx  = master_addr_i[2 +: IDX_W];
  assign req_oor  = (master_addr_i >> (IDX_W + 2)) != '0;

  // The load accepted alongside clear_i sits in the meta stage, so drain must see it too.
  assign pipe_busy = meta_val_q | pipe_any_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (clear_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      meta_val_q <= 1'b0;
      meta_oor_q <= 1'b0;
      meta_opq_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      meta_val_q <= accept & ~is_store;
      if (accept) begin
        meta_opq_q <= master_opq_i;
        meta_oor_q <= req_oor;
      end
      if (accept & req_oor) err_q <= 1'b1;
    end
  end

  // Single port shared by the zero-fill counter and the request port.
  assign init_we   = (state_q == ST_INIT);
  assign ram_idx   = init_we ? cnt_q : req_idx;
  assign ram_we    = init_we | (accept & is_store & ~req_oor);
  assign ram_re    = accept & ~is_store;
  assign ram_be    = init_we ? '1 : master_mask_i;
  assign ram_wdata = init_we ? '0 : master_data_i;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (ram_be[b]) mem_q[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    if (ram_re) rd_q <= mem_q[ram_idx];
  end

  always_comb begin
    pipe_in      = '0;
    pipe_in.val  = meta_val_q;
    pipe_in.opq  = RESP_OPQ_W'(meta_opq_q);
    pipe_in.data = RESP_DATA_W'(meta_oor_q ? err_data_p : rd_q);
  end

  brg_xcel_resp_pipe #(
    .depth_p(int'(latency_p))
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .in_i       (pipe_in),
    .out_o      (pipe_out),
    .any_valid_o(pipe_any_valid)
  );

  assign master_ret_val_o  = pipe_out.val;
  assign master_ret_data_o = pipe_out.data[data_width_p-1:0];
  assign master_ret_opq_o  = pipe_out.opq[load_id_width_p-1:0];

  // Padding bits of the response payload and the byte offset are intentionally dropped.
  assign unused_bits = ^{pipe_out, master_addr_i[1:0]};

endmodule
